// File: rtl/keypad_emulator.sv
// keypad_emulator: passive 4x4 matrix keypad model.
// Press requests are queued in a small FIFO and replayed one at a time.
// A replayed key pulls its column low whenever the scanner drives its row low.
module keypad_emulator #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned HOLD_WIDTH = 8,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [3:0]                    req_key,
  input  logic [HOLD_WIDTH-1:0]         req_hold,
  input  logic [3:0]                    row_n,
  output logic [3:0]                    col_n,
  output logic                          held,
  output logic [3:0]                    held_key,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);
  localparam int unsigned ENTRY_W = 4 + HOLD_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [ENTRY_W-1:0]    r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic [1:0]            r_state;
  logic [HOLD_WIDTH-1:0] r_hold_cnt;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic [3:0]            r_held_key;
  logic                  r_held;
  logic                  r_done;

  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [ENTRY_W-1:0]    w_rd_entry;
  logic [3:0]            w_rd_key;
  logic [HOLD_WIDTH-1:0] w_rd_hold;

  logic [1:0]            w_state_nxt;
  logic [HOLD_WIDTH-1:0] w_hold_nxt;
  logic [GAP_W-1:0]      w_gap_nxt;
  logic [3:0]            w_key_nxt;
  logic                  w_held_nxt;
  logic                  w_done_nxt;

  logic [7:0]            w_pos;
  logic [3:0]            w_key_row_n;
  logic [3:0]            w_key_col_n;

  // Matrix position of a key as {row pattern, column pattern}, both active-low.
  function automatic logic [7:0] key_pos(input logic [3:0] key);
    logic [7:0] pos;
    case (key)
      4'hF:    pos = 8'b0111_0111;
      4'hE:    pos = 8'b0111_1011;
      4'hD:    pos = 8'b0111_1101;
      4'hC:    pos = 8'b0111_1110;
      4'hB:    pos = 8'b1011_0111;
      4'h3:    pos = 8'b1011_1011;
      4'h6:    pos = 8'b1011_1101;
      4'h9:    pos = 8'b1011_1110;
      4'hA:    pos = 8'b1101_0111;
      4'h2:    pos = 8'b1101_1011;
      4'h5:    pos = 8'b1101_1101;
      4'h8:    pos = 8'b1101_1110;
      4'h0:    pos = 8'b1110_0111;
      4'h1:    pos = 8'b1110_1011;
      4'h4:    pos = 8'b1110_1101;
      default: pos = 8'b1110_1110;
    endcase
    return pos;
  endfunction

  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push     = req_valid && !w_full;
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign w_rd_entry = r_mem[r_rd_ptr];
  assign w_rd_key   = w_rd_entry[ENTRY_W-1:HOLD_WIDTH];
  assign w_rd_hold  = w_rd_entry[HOLD_WIDTH-1:0];

  assign req_ready  = !w_full;
  assign fifo_count = r_count;
  assign held       = r_held;
  assign held_key   = r_held_key;
  assign done       = r_done;

  // Zero-latency column readout, like a physical switch matrix.
  assign w_pos       = key_pos(r_held_key);
  assign w_key_row_n = w_pos[7:4];
  assign w_key_col_n = w_pos[3:0];
  assign col_n = (r_held && ((~row_n & ~w_key_row_n) != 4'b0000)) ? w_key_col_n : 4'b1111;

  // Request storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {req_key, req_hold};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Press sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
      r_held_key <= 4'h0;
      r_held     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_held_key <= w_key_nxt;
      r_held     <= w_held_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Press sequencer next state: pop -> hold for max(hold,1) -> release gap.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_key_nxt   = r_held_key;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_key_nxt   = w_rd_key;
          w_hold_nxt  = (w_rd_hold == '0) ? HOLD_WIDTH'(1) : w_rd_hold;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_hold_cnt == HOLD_WIDTH'(1)) begin
          w_gap_nxt   = GAP_W'(GAP_CYCLES);
          w_state_nxt = S_GAP;
        end else begin
          w_hold_nxt = r_hold_cnt - HOLD_WIDTH'(1);
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_W'(1)) w_state_nxt = S_IDLE;
        else                        w_gap_nxt   = r_gap_cnt - GAP_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_held_nxt = (w_state_nxt == S_HOLD);
    w_done_nxt = (w_state_nxt == S_HOLD) && (w_hold_nxt == HOLD_WIDTH'(1));
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed self-checking bench for keypad_emulator.
module tb_keypad_emulator;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned HOLD_WIDTH = 8;
  localparam int unsigned GAP_CYCLES = 16;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_key;
  logic [7:0]  req_hold;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        held;
  logic [3:0]  held_key;
  logic        done;
  logic [2:0]  fifo_count;

  int n_cmp;
  int n_fail;

  keypad_emulator #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .HOLD_WIDTH(HOLD_WIDTH),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_key    (req_key),
    .req_hold   (req_hold),
    .row_n      (row_n),
    .col_n      (col_n),
    .held       (held),
    .held_key   (held_key),
    .done       (done),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] rows [4];
    rows[0] = 4'b0111; rows[1] = 4'b1011; rows[2] = 4'b1101; rows[3] = 4'b1110;
    rst_n = 1'b0; req_valid = 1'b0; req_key = 4'h0; req_hold = 8'd0; row_n = 4'b1111;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    n_cmp++;
    if ({held, held_key, done, col_n, req_ready, fifo_count} !== {1'b0, 4'h0, 1'b0, 4'hF, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got held=%b key=%h done=%b col=%b rdy=%b cnt=%0d, want 0 0 0 1111 1 0",
               held, held_key, done, col_n, req_ready, fifo_count);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      row_n = rows[i];
      @(negedge clk);
      n_cmp++;
      if ({col_n, req_ready, fifo_count} !== {4'hF, 1'b1, 3'd0}) begin
        n_fail++;
        $display("FAIL idle_scan row=%b: got col=%b rdy=%b cnt=%0d, want 1111 1 0",
                 row_n, col_n, req_ready, fifo_count);
      end
    end
    step();
  endtask

  // One press from an empty idle queue; cycle 0 is the request cycle.
  task automatic run_press(input logic [3:0] key, input logic [7:0] hold, input logic [3:0] row,
                           input logic [3:0] exp_col, input int exp_len, input string name);
    logic on;
    for (int c = 0; c < exp_len + 5; c++) begin
      req_valid = (c == 0);
      req_key   = key;
      req_hold  = hold;
      row_n     = row;
      @(negedge clk);
      on = (c >= 2) && (c < 2 + exp_len);
      n_cmp++;
      if (held !== on || done !== (c == exp_len + 1) || col_n !== (on ? exp_col : 4'hF)) begin
        n_fail++;
        $display("FAIL %s c=%0d: got held=%b done=%b col=%b, want held=%b done=%b col=%b",
                 name, c, held, done, col_n, on, (c == exp_len + 1), (on ? exp_col : 4'hF));
      end
      if (on) begin
        n_cmp++;
        if (held_key !== key) begin
          n_fail++;
          $display("FAIL %s_key c=%0d: got %h, want %h", name, c, held_key, key);
        end
      end
      step();
    end
    req_valid = 1'b0;
    repeat (14) step();
  endtask

  task automatic test_press_match();
    run_press(4'h5, 8'd8, 4'b1101, 4'b1101, 8, "press_match");
  endtask

  task automatic test_press_other_row();
    run_press(4'h5, 8'd8, 4'b1110, 4'b1111, 8, "press_other_row");
  endtask

  task automatic test_zero_hold();
    run_press(4'hA, 8'd0, 4'b1101, 4'b0111, 1, "zero_hold");
  endtask

  // Every key, each row strobed in turn plus all rows low together.
  task automatic test_key_map();
    logic [3:0] layout [4][4];
    logic [3:0] seq [5];
    logic [3:0] one_hot;
    logic [3:0] exp_row;
    logic [3:0] exp_col;
    logic [3:0] want;
    layout[0][0] = 4'hF; layout[0][1] = 4'hE; layout[0][2] = 4'hD; layout[0][3] = 4'hC;
    layout[1][0] = 4'hB; layout[1][1] = 4'h3; layout[1][2] = 4'h6; layout[1][3] = 4'h9;
    layout[2][0] = 4'hA; layout[2][1] = 4'h2; layout[2][2] = 4'h5; layout[2][3] = 4'h8;
    layout[3][0] = 4'h0; layout[3][1] = 4'h1; layout[3][2] = 4'h4; layout[3][3] = 4'h7;
    seq[0] = 4'b0111; seq[1] = 4'b1011; seq[2] = 4'b1101; seq[3] = 4'b1110; seq[4] = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        one_hot = 4'b1000 >> r;
        exp_row = ~one_hot;
        one_hot = 4'b1000 >> k;
        exp_col = ~one_hot;
        for (int c = 0; c < 7; c++) begin
          req_valid = (c == 0);
          req_key   = layout[r][k];
          req_hold  = 8'd5;
          row_n     = (c < 2) ? exp_row : seq[c-2];
          @(negedge clk);
          if (c < 2) want = 4'hF;
          else want = (seq[c-2] == exp_row || seq[c-2] == 4'b0000) ? exp_col : 4'hF;
          n_cmp++;
          if (col_n !== want) begin
            n_fail++;
            $display("FAIL key_map key=%h row=%b: got col=%b, want %b", layout[r][k], row_n, col_n, want);
          end
          step();
        end
        req_valid = 1'b0;
        row_n     = 4'b1111;
        repeat (16) step();
      end
    end
  endtask

  // Six queued presses; the sixth arrives while full and must wait for a free slot.
  task automatic test_back_to_back();
    logic [3:0] keys [6];
    logic [3:0] got_key [6];
    int         starts [6];
    int         n_press;
    int         idx;
    int         accept6;
    logic       prev_held;
    keys[0] = 4'hF; keys[1] = 4'h3; keys[2] = 4'h9; keys[3] = 4'h0; keys[4] = 4'h7; keys[5] = 4'h1;
    n_press = 0; idx = 0; accept6 = -1; prev_held = 1'b0;
    row_n = 4'b1111;
    for (int c = 0; c < 135; c++) begin
      req_valid = (idx < 6);
      req_key   = (idx < 6) ? keys[idx] : 4'h0;
      req_hold  = 8'd4;
      @(negedge clk);
      if (c == 5 || c == 22) begin
        n_cmp++;
        if (req_ready !== 1'b0 || fifo_count !== 3'd4) begin
          n_fail++;
          $display("FAIL b2b_full c=%0d: got rdy=%b cnt=%0d, want 0 4", c, req_ready, fifo_count);
        end
      end
      if (c == 23) begin
        n_cmp++;
        if (req_ready !== 1'b1 || fifo_count !== 3'd3) begin
          n_fail++;
          $display("FAIL b2b_free c=%0d: got rdy=%b cnt=%0d, want 1 3", c, req_ready, fifo_count);
        end
      end
      if (held && !prev_held && n_press < 6) begin
        starts[n_press]  = c;
        got_key[n_press] = held_key;
        n_press++;
      end
      prev_held = held;
      if (req_valid && req_ready) begin
        if (idx == 5) accept6 = c;
        idx++;
      end
      step();
    end
    req_valid = 1'b0;
    n_cmp++;
    if (accept6 !== 23 || n_press !== 6) begin
      n_fail++;
      $display("FAIL b2b_accept: got accept=%0d presses=%0d, want 23 6", accept6, n_press);
    end
    for (int i = 0; i < 6; i++) begin
      if (i < n_press) begin
        n_cmp++;
        if (got_key[i] !== keys[i] || starts[i] !== 2 + 21 * i) begin
          n_fail++;
          $display("FAIL b2b_press%0d: got key=%h start=%0d, want key=%h start=%0d",
                   i, got_key[i], starts[i], keys[i], 2 + 21 * i);
        end
      end
    end
  endtask

  // Asynchronous reset during HOLD with two more requests queued.
  task automatic test_reset_mid_hold();
    for (int c = 0; c < 5; c++) begin
      req_valid = (c < 3);
      req_key   = (c == 0) ? 4'h5 : ((c == 1) ? 4'h3 : 4'h9);
      req_hold  = 8'd8;
      row_n     = 4'b1101;
      step();
    end
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (held !== 1'b1 || fifo_count !== 3'd2 || col_n !== 4'b1101) begin
      n_fail++;
      $display("FAIL pre_reset: got held=%b cnt=%0d col=%b, want 1 2 1101", held, fifo_count, col_n);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({held, col_n, fifo_count, done, req_ready} !== {1'b0, 4'hF, 3'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_reset: got held=%b col=%b cnt=%0d done=%b rdy=%b, want 0 1111 0 0 1",
               held, col_n, fifo_count, done, req_ready);
    end
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      @(negedge clk);
      n_cmp++;
      if (held !== 1'b0 || done !== 1'b0 || col_n !== 4'hF) begin
        n_fail++;
        $display("FAIL post_reset c=%0d: got held=%b done=%b col=%b, want 0 0 1111", c, held, done, col_n);
      end
    end
    step();
    run_press(4'h5, 8'd8, 4'b1101, 4'b1101, 8, "press_after_reset");
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_press_match();
    test_press_other_row();
    test_zero_hold();
    test_key_map();
    test_back_to_back();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
